// File: rtl/btn_event_gen.sv
// btn_event_gen: synchronizes, debounces and turns pushbuttons into
// clean levels plus one-cycle press, release and auto-repeat events.
module btn_event_gen #(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HW = $clog2(HOLD_CYC) + 1;
  localparam int RW = $clog2(REPEAT_CYC) + 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [N_BTN-1:0] meta;
  logic [N_BTN-1:0] sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_raw;
      sync <= meta;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          repeat_q;
    state_t        state;
    state_t        state_nxt;
    logic          differ;
    logic          db_done;
    logic          rise;
    logic          fall;
    logic          hold_done;
    logic          rep_done;
    logic          fire;

    assign differ    = sync[i] ^ level_q;
    assign db_done   = differ && (db_cnt == DB_LAST);
    assign rise      = db_done && !level_q;
    assign fall      = db_done && level_q;
    assign hold_done = (state == HELD) && (hold_cnt == HOLD_LAST);
    assign rep_done  = (state == REPEAT) && (rep_cnt == REP_LAST);

    // level flips only after DEBOUNCE_CYC consecutive differing cycles
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (!differ) begin
        db_cnt  <= '0;
      end else if (db_done) begin
        db_cnt  <= '0;
        level_q <= ~level_q;
      end else begin
        db_cnt  <= db_cnt + DW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= IDLE;
      end else begin
        state <= state_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      unique case (state)
        IDLE: begin
          if (rise) state_nxt = HELD;
        end
        HELD: begin
          if (fall)           state_nxt = IDLE;
          else if (hold_done) state_nxt = REPEAT;
        end
        REPEAT: begin
          if (fall) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // a release edge always wins over a due repeat
    always_comb begin
      fire = 1'b0;
      if ((hold_done || rep_done) && !fall) fire = 1'b1;
    end

    // counters restart whenever they fire or leave their state
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else begin
        if (state == HELD && !fall && !hold_done) begin
          hold_cnt <= hold_cnt + HW'(1);
        end else begin
          hold_cnt <= '0;
        end
        if (state == REPEAT && !fall && !rep_done) begin
          rep_cnt <= rep_cnt + RW'(1);
        end else begin
          rep_cnt <= '0;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= rise;
        release_q <= fall;
        repeat_q  <= fire;
      end
    end

    assign btn_level[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign repeat_pulse[i]  = repeat_q;
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: directed and random stimulus for btn_event_gen,
// checked every cycle against a cycle-history reference model.
module tb_btn_event_gen;

  localparam int NB   = 4;
  localparam int DB   = 4;
  localparam int HC   = 20;
  localparam int RC   = 5;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic [NB-1:0] repeat_pulse;

  always #5 clk = ~clk;

  btn_event_gen #(
    .N_BTN(NB),
    .DEBOUNCE_CYC(DB),
    .HOLD_CYC(HC),
    .REPEAT_CYC(RC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse)
  );

  int checks = 0;
  int errors = 0;

  logic [NB-1:0] raw_h[MAXC];
  logic [NB-1:0] lvl_h[MAXC];
  int            press_t[NB];
  int            t;
  logic [NB-1:0] cur_raw;

  int n_press[NB];
  int n_rel[NB];
  int n_rep[NB];
  int obs_press_t[NB];
  int obs_rel_t[NB];
  int obs_rep_t[NB];
  int t0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h",
               tag, t, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] sync_at(int k);
    return (k >= 2) ? raw_h[k-2] : '0;
  endfunction

  task automatic clr_counts();
    for (int i = 0; i < NB; i++) begin
      n_press[i]     = 0;
      n_rel[i]       = 0;
      n_rep[i]       = 0;
      obs_press_t[i] = -1000;
      obs_rel_t[i]   = -1000;
      obs_rep_t[i]   = -1000;
    end
  endtask

  task automatic start_epoch();
    t = 0;
    lvl_h[0] = '0;
    for (int i = 0; i < NB; i++) press_t[i] = 0;
    check("rst_level", 32'(btn_level), 32'(0));
    check("rst_press", 32'(press_pulse), 32'(0));
    check("rst_release", 32'(release_pulse), 32'(0));
    check("rst_repeat", 32'(repeat_pulse), 32'(0));
  endtask

  task automatic step(logic [NB-1:0] r);
    logic [NB-1:0] lv, pr, rl, rp, s;
    bit flip;
    int d;
    btn_raw  = r;
    raw_h[t] = r;
    @(posedge clk);
    t++;
    #1;
    if (t >= MAXC - 1) begin
      $display("FAIL model_bound: history exhausted at %0d", t);
      $fatal(1);
    end
    lv = lvl_h[t-1];
    pr = '0;
    rl = '0;
    rp = '0;
    for (int i = 0; i < NB; i++) begin
      if (t >= DB) begin
        flip = 1'b1;
        for (int k = t - DB; k < t; k++) begin
          s = sync_at(k);
          if (s[i] == lvl_h[t-1][i]) flip = 1'b0;
        end
        if (flip) lv[i] = ~lv[i];
      end
    end
    lvl_h[t] = lv;
    for (int i = 0; i < NB; i++) begin
      if (lv[i] && !lvl_h[t-1][i]) begin
        pr[i] = 1'b1;
        press_t[i] = t;
      end
      if (!lv[i] && lvl_h[t-1][i]) rl[i] = 1'b1;
      if (lv[i] && lvl_h[t-1][i]) begin
        d = t - press_t[i];
        if (d == HC || (d > HC && (d - HC) % RC == 0)) rp[i] = 1'b1;
      end
    end
    check("level", 32'(btn_level), 32'(lv));
    check("press", 32'(press_pulse), 32'(pr));
    check("release", 32'(release_pulse), 32'(rl));
    check("repeat", 32'(repeat_pulse), 32'(rp));
    for (int i = 0; i < NB; i++) begin
      if (press_pulse[i]) begin
        n_press[i]++;
        obs_press_t[i] = t;
      end
      if (release_pulse[i]) begin
        n_rel[i]++;
        obs_rel_t[i] = t;
      end
      if (repeat_pulse[i]) begin
        if (n_rep[i] == 0) obs_rep_t[i] = t;
        n_rep[i]++;
      end
    end
  endtask

  task automatic drive(logic [NB-1:0] r, int n);
    cur_raw = r;
    repeat (n) step(r);
  endtask

  initial begin
    int p;
    int rem[NB];
    logic [NB-1:0] rr;
    reset_n = 1'b0;
    btn_raw = '0;
    cur_raw = '0;
    t = 0;
    clr_counts();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    start_epoch();

    // 1: clean press
    clr_counts();
    t0 = t;
    drive(4'b0001, 12);
    check("t1_latency", 32'(obs_press_t[0] - t0), 32'(6));
    check("t1_press_cnt", 32'(n_press[0]), 32'(1));
    check("t1_others", 32'(btn_level[3:1]), 32'(0));
    drive(4'b0000, 12);

    // 2: glitch rejection
    clr_counts();
    drive(4'b0010, 3);
    drive(4'b0000, 10);
    for (int j = 0; j < 15; j++) drive(j[0] ? 4'b0000 : 4'b0010, 2);
    drive(4'b0000, 10);
    check("t2_press", 32'(n_press[1]), 32'(0));
    check("t2_release", 32'(n_rel[1]), 32'(0));
    check("t2_repeat", 32'(n_rep[1]), 32'(0));

    // 3: hold and repeat
    clr_counts();
    drive(4'b0100, 6);
    p = obs_press_t[2];
    drive(4'b0100, 60);
    t0 = t;
    drive(4'b0000, 12);
    check("t3_first_rep", 32'(obs_rep_t[2] - p), 32'(HC));
    check("t3_rep_cnt", 32'(n_rep[2]), 32'(10));
    check("t3_rel_cnt", 32'(n_rel[2]), 32'(1));
    check("t3_rel_lat", 32'(obs_rel_t[2] - t0), 32'(6));

    // 4: release before hold threshold
    clr_counts();
    drive(4'b1000, 6);
    drive(4'b1000, 10);
    drive(4'b0000, 12);
    check("t4_press", 32'(n_press[3]), 32'(1));
    check("t4_release", 32'(n_rel[3]), 32'(1));
    check("t4_repeat", 32'(n_rep[3]), 32'(0));

    // 5: simultaneous
    drive(4'b1111, 6);
    check("t5_press", 32'(press_pulse), 32'(4'hf));
    drive(4'b1111, 4);
    drive(4'b0000, 6);
    check("t5_release", 32'(release_pulse), 32'(4'hf));
    drive(4'b0000, 6);

    // 6: async reset during repeat
    drive(4'b0001, 31);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_out", 32'({btn_level, press_pulse,
                             release_pulse, repeat_pulse}), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    start_epoch();
    clr_counts();
    t0 = t;
    drive(4'b0001, 8);
    check("t6_repress", 32'(obs_press_t[0] - t0), 32'(6));
    drive(4'b0000, 12);

    // random segments: short bounces mixed with long holds
    rr = cur_raw;
    for (int i = 0; i < NB; i++) rem[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (rem[i] == 0) begin
          rr[i] = 1'($urandom_range(0, 1));
          rem[i] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(20, 70)) :
                   int'($urandom_range(1, 8));
        end
        rem[i]--;
      end
      cur_raw = rr;
      step(rr);
    end
    drive(4'b0000, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_event_gen.md
Name: btn_event_gen

Overview:
Input conditioning stage for the push-button/LED lab designs. It sits directly upstream of the counter/brightness control logic and converts raw, asynchronous, bouncy pushbutton inputs into clean per-button levels and single-cycle events. The events are press, release and hold-to-repeat, and the control logic consumes them directly instead of doing its own edge detection. All buttons are handled by independent identical channels inside one block.

Parameters:
N_BTN, 4, number of independent button channels
DEBOUNCE_CYC, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz)
HOLD_CYC, 50000000, cycles a button must stay pressed before the first repeat event (0.5 s)
REPEAT_CYC, 10000000, cycles between subsequent repeat events while still held (0.1 s)

Ports:
clk  input  1  system clock, 100 MHz
reset_n  input  1  asynchronous active-low reset
btn_raw  input  N_BTN  raw pushbutton inputs, asynchronous to clk, 1 = pressed
btn_level  output  N_BTN  debounced button level, 1 = pressed
press_pulse  output  N_BTN  one-cycle pulse when btn_level goes 0->1
release_pulse  output  N_BTN  one-cycle pulse when btn_level goes 1->0
repeat_pulse  output  N_BTN  one-cycle auto-repeat pulse while the button is held

Behaviour:
- One clock domain (clk). reset_n is asynchronous and active-low: assertion immediately clears all state, and deassertion is synchronous-safe.
- Reset values: btn_level, press_pulse, release_pulse and repeat_pulse are all 0. Synchronizer flops, debounce counters, hold/repeat counters and channel FSMs are also cleared to 0 / IDLE.
- Per channel, a 2-flop synchronizer on btn_raw[i] produces sync[i]. Only sync[i] is used downstream.
- Debounce rule:
  - Counter db_cnt increments each cycle that sync != btn_level.
  - Counter clears in any cycle that sync == btn_level.
  - When db_cnt reaches DEBOUNCE_CYC-1 while still differing, btn_level toggles on the next edge and db_cnt clears.
  - Net latency from a clean raw edge to btn_level change is 2 + DEBOUNCE_CYC cycles.
  - Any bounce shorter than DEBOUNCE_CYC cycles produces no level change and no events.
- Event outputs are registered and asserted for exactly one cycle, in the same cycle that btn_level first shows its new value:
  - press_pulse on a 0->1 transition.
  - release_pulse on a 1->0 transition.
  - press_pulse and release_pulse of one channel are never high together.
- Per-channel FSM: IDLE -> HELD on press. HELD -> REPEAT when hold_cnt reaches HOLD_CYC. REPEAT loops while held. HELD or REPEAT -> IDLE on release.
- Hold/repeat timing:
  - hold_cnt counts from the press cycle (press cycle = 0).
  - The first repeat_pulse fires at cycle HOLD_CYC after press_pulse.
  - Subsequent repeat_pulses fire every REPEAT_CYC cycles.
  - No repeat_pulse is issued in the release cycle or after it. A release clears hold_cnt.
- Counter widths are $clog2 of the respective parameter plus 1. Counters saturate or reload and never wrap silently.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses on each.
- Reset mid-operation aborts any pending debounce or repeat. After deassertion, a button still physically held is re-debounced and reports a fresh press_pulse.
- Parameters must satisfy DEBOUNCE_CYC >= 2, HOLD_CYC >= 1 and REPEAT_CYC >= 1. Behaviour outside these ranges is undefined.

Test Plan:
(Bench parameters: DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=5, N_BTN=4.)
1. Clean press: btn_raw[0] rises at cycle 0 and stays high -> btn_level[0] and press_pulse[0] rise at cycle 6. press_pulse[0] is high exactly 1 cycle, and no other channel toggles.
2. Glitch rejection: btn_raw[1] high for 3 cycles, then low; later 0/1 toggling every 2 cycles for 30 cycles -> btn_level[1] stays 0, with no press, release or repeat pulses.
3. Hold/repeat: hold btn_raw[2] high for 60 cycles after its press_pulse at cycle P -> repeat_pulse[2] at P+20, P+25, P+30 and so on. After release, exactly one release_pulse[2] appears 6 cycles after btn_raw falls, with no further repeats.
4. Release before hold threshold: press btn_raw[3], release at press+10 -> one press_pulse and one release_pulse, zero repeat_pulse.
5. Simultaneous: btn_raw=4'b1111 at cycle 0 -> press_pulse=4'b1111 in the same cycle (cycle 6). btn_raw=4'b0000 later -> release_pulse=4'b1111 together.
6. Async reset mid-hold: assert reset_n low between clock edges during REPEAT -> all outputs 0 immediately. After deassertion with btn_raw[0] still high, a new press_pulse[0] appears 6 cycles later.
